eth_recv: RTL and testbench

- GMII receive-side MAC framer; the counterpart of the team's GMII transmit framer.
- Detects preamble and SFD, then parses the destination MAC, source MAC and type/length fields.
- Filters frames on destination address and streams payload bytes into a write-side FIFO.
- Checks the CRC-32 FCS and reports per-frame status to the protocol layer (ARP/IP parser) that drains the FIFO.

---
 rtl/eth_recv_if.sv | 8 +
 rtl/eth_recv.sv | 248 ++++++++++++++++++++++++
 tb/tb_eth_recv.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_recv_if.sv
// Write side of the payload FIFO: one byte per cycle while fifo_wrreq is high.
interface eth_recv_if;
  logic       fifo_wrreq;
  logic [7:0] fifo_data;

  modport master (output fifo_wrreq, output fifo_data);
  modport slave  (input  fifo_wrreq, input  fifo_data);
endinterface

// File: rtl/eth_recv.sv
// GMII receive framer: preamble/SFD detection, header parse, address filter,
// FCS-stripping payload stream into a FIFO and per-frame status.
module eth_recv #(
  parameter int unsigned MAX_PAYLOAD  = 1500,
  parameter int unsigned PREAMBLE_MIN = 1
) (
  input  logic              gmii_rx_clk,
  input  logic              rst_n,
  input  logic [7:0]        gmii_rx_data,
  input  logic              gmii_rx_dv,
  input  logic              gmii_rx_er,
  input  logic [47:0]       local_mac_addr,
  output logic              fifo_wrclk,
  eth_recv_if.master        fifo_if,
  output logic [47:0]       rx_dst_mac,
  output logic [47:0]       rx_src_mac,
  output logic [15:0]       rx_frame_type,
  output logic [15:0]       rx_data_length,
  output logic              rx_done,
  output logic              rx_crc_ok,
  output logic              rx_err
);

  localparam int unsigned PRE_W   = 8;
  localparam int unsigned LEN_W   = 16;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RES  = 32'hDEBB_20E3;

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, DST, SRC, TYPE, DATA, DONE, DROP
  } state_t;

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [2:0]         hdr_cnt_q, hdr_cnt_d;
  logic [47:0]        dst_sh_q, dst_sh_d;
  logic [47:0]        src_sh_q, src_sh_d;
  logic [15:0]        type_sh_q, type_sh_d;
  logic [31:0]        dly_q, dly_d;
  logic [2:0]         fill_q, fill_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovs_q, ovs_d;
  logic               err_q, err_d;
  logic [31:0]        crc_q, crc_d;
  logic               wrreq_q, wrreq_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [47:0]        dst_mac_q, dst_mac_d;
  logic [47:0]        src_mac_q, src_mac_d;
  logic [15:0]        ftype_q, ftype_d;
  logic [LEN_W-1:0]   dlen_q, dlen_d;
  logic               done_q, done_d;
  logic               crc_ok_q, crc_ok_d;
  logic               rerr_q, rerr_d;
  logic               runt_c;

  // Reflected CRC-32 update, one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ (((r[0] ^ b[i]) == 1'b1) ? CRC_POLY : 32'h0);
    end
    return r;
  endfunction

  assign fifo_wrclk         = gmii_rx_clk;
  assign fifo_if.fifo_wrreq = wrreq_q;
  assign fifo_if.fifo_data  = wdata_q;
  assign rx_dst_mac         = dst_mac_q;
  assign rx_src_mac         = src_mac_q;
  assign rx_frame_type      = ftype_q;
  assign rx_data_length     = dlen_q;
  assign rx_done            = done_q;
  assign rx_crc_ok          = crc_ok_q;
  assign rx_err             = rerr_q;

  // Fewer than four DATA bytes means no complete FCS arrived.
  assign runt_c = (fill_q != 3'd4);

  // State and datapath registers.
  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pre_cnt_q <= '0;
      hdr_cnt_q <= '0;
      dst_sh_q  <= '0;
      src_sh_q  <= '0;
      type_sh_q <= '0;
      dly_q     <= '0;
      fill_q    <= '0;
      len_q     <= '0;
      ovs_q     <= 1'b0;
      err_q     <= 1'b0;
      crc_q     <= CRC_INIT;
      wrreq_q   <= 1'b0;
      wdata_q   <= '0;
      dst_mac_q <= '0;
      src_mac_q <= '0;
      ftype_q   <= '0;
      dlen_q    <= '0;
      done_q    <= 1'b0;
      crc_ok_q  <= 1'b0;
      rerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      hdr_cnt_q <= hdr_cnt_d;
      dst_sh_q  <= dst_sh_d;
      src_sh_q  <= src_sh_d;
      type_sh_q <= type_sh_d;
      dly_q     <= dly_d;
      fill_q    <= fill_d;
      len_q     <= len_d;
      ovs_q     <= ovs_d;
      err_q     <= err_d;
      crc_q     <= crc_d;
      wrreq_q   <= wrreq_d;
      wdata_q   <= wdata_d;
      dst_mac_q <= dst_mac_d;
      src_mac_q <= src_mac_d;
      ftype_q   <= ftype_d;
      dlen_q    <= dlen_d;
      done_q    <= done_d;
      crc_ok_q  <= crc_ok_d;
      rerr_q    <= rerr_d;
    end
  end

  // Next-state, header shift, delay line, CRC and status logic.
  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    hdr_cnt_d = hdr_cnt_q;
    dst_sh_d  = dst_sh_q;
    src_sh_d  = src_sh_q;
    type_sh_d = type_sh_q;
    dly_d     = dly_q;
    fill_d    = fill_q;
    len_d     = len_q;
    ovs_d     = ovs_q;
    err_d     = err_q;
    crc_d     = crc_q;
    wrreq_d   = 1'b0;
    wdata_d   = wdata_q;
    dst_mac_d = dst_mac_q;
    src_mac_d = src_mac_q;
    ftype_d   = ftype_q;
    dlen_d    = dlen_q;
    done_d    = 1'b0;
    crc_ok_d  = crc_ok_q;
    rerr_d    = rerr_q;

    case (state_q)
      IDLE: begin
        if (gmii_rx_dv && (gmii_rx_data == 8'h55)) begin
          state_d   = PREAMBLE;
          pre_cnt_d = PRE_W'(1);
        end
      end
      PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_d = IDLE;
        end else if (gmii_rx_data == 8'h55) begin
          if (pre_cnt_q != '1) pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end else if ((gmii_rx_data == 8'hD5) && (pre_cnt_q >= PRE_W'(PREAMBLE_MIN))) begin
          state_d   = DST;
          hdr_cnt_d = '0;
          crc_d     = CRC_INIT;
          err_d     = gmii_rx_er;
          fill_d    = '0;
          len_d     = '0;
          ovs_d     = 1'b0;
        end else begin
          state_d = DROP;
        end
      end
      DST, SRC, TYPE: begin
        if (!gmii_rx_dv) begin
          state_d = IDLE;
        end else begin
          crc_d     = crc_byte(crc_q, gmii_rx_data);
          err_d     = err_q | gmii_rx_er;
          hdr_cnt_d = hdr_cnt_q + 3'd1;
          if (state_q == DST) begin
            dst_sh_d = {dst_sh_q[39:0], gmii_rx_data};
            if (hdr_cnt_q == 3'd5) begin
              state_d   = SRC;
              hdr_cnt_d = '0;
            end
          end else if (state_q == SRC) begin
            src_sh_d = {src_sh_q[39:0], gmii_rx_data};
            if (hdr_cnt_q == 3'd5) begin
              state_d   = TYPE;
              hdr_cnt_d = '0;
            end
          end else begin
            type_sh_d = {type_sh_q[7:0], gmii_rx_data};
            if (hdr_cnt_q == 3'd1) begin
              hdr_cnt_d = '0;
              if ((dst_sh_q == local_mac_addr) || (dst_sh_q == 48'hFFFF_FFFF_FFFF)) begin
                state_d = DATA;
              end else begin
                state_d = DROP;
              end
            end
          end
        end
      end
      DATA: begin
        if (!gmii_rx_dv) begin
          state_d = DONE;
        end else begin
          crc_d = crc_byte(crc_q, gmii_rx_data);
          err_d = err_q | gmii_rx_er;
          dly_d = {dly_q[23:0], gmii_rx_data};
          if (fill_q == 3'd4) begin
            // Oldest byte is now known not to be FCS; write it unless at the cap.
            if (len_q == LEN_W'(MAX_PAYLOAD)) begin
              ovs_d = 1'b1;
            end else begin
              wrreq_d = 1'b1;
              wdata_d = dly_q[31:24];
              len_d   = len_q + LEN_W'(1);
            end
          end else begin
            fill_d = fill_q + 3'd1;
          end
        end
      end
      DONE: begin
        state_d   = IDLE;
        done_d    = 1'b1;
        dst_mac_d = dst_sh_q;
        src_mac_d = src_sh_q;
        ftype_d   = type_sh_q;
        dlen_d    = len_q;
        crc_ok_d  = !runt_c && (crc_q == CRC_RES);
        rerr_d    = err_q | runt_c | ovs_q;
      end
      DROP: begin
        if (!gmii_rx_dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_eth_recv.sv
// Self-checking bench for eth_recv: directed frames plus randomized frames,
// checked against a frame-level model of the expected FIFO writes and status.
module tb_eth_recv;

  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;
  localparam int          MAXP    = 1500;

  logic        gmii_rx_clk = 1'b0;
  logic        rst_n;
  logic [7:0]  gmii_rx_data;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic [47:0] local_mac_addr;
  logic        fifo_wrclk;
  logic [47:0] rx_dst_mac, rx_src_mac;
  logic [15:0] rx_frame_type, rx_data_length;
  logic        rx_done, rx_crc_ok, rx_err;

  eth_recv_if fif ();

  eth_recv dut (
    .gmii_rx_clk    (gmii_rx_clk),
    .rst_n          (rst_n),
    .gmii_rx_data   (gmii_rx_data),
    .gmii_rx_dv     (gmii_rx_dv),
    .gmii_rx_er     (gmii_rx_er),
    .local_mac_addr (local_mac_addr),
    .fifo_wrclk     (fifo_wrclk),
    .fifo_if        (fif),
    .rx_dst_mac     (rx_dst_mac),
    .rx_src_mac     (rx_src_mac),
    .rx_frame_type  (rx_frame_type),
    .rx_data_length (rx_data_length),
    .rx_done        (rx_done),
    .rx_crc_ok      (rx_crc_ok),
    .rx_err         (rx_err)
  );

  always #4 gmii_rx_clk = ~gmii_rx_clk;

  typedef struct {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] typ;
    logic [15:0] len;
    logic        crc_ok;
    logic        err;
  } done_t;

  done_t       exp_done[$];
  logic [7:0]  exp_wr[$];
  logic [7:0]  pay[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_cnt   = 0;
  int          done_cnt = 0;
  logic        last_crc_ok = 1'b0;
  logic        last_err    = 1'b0;
  logic [47:0] held_dst = '0, held_src = '0;
  logic [15:0] held_typ = '0, held_len = '0;
  done_t       cur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event occurred with nothing expected", name);
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Per-cycle compare against the model, sampled just after the active edge.
  always @(posedge gmii_rx_clk) begin
    #1;
    check("wrclk", {63'b0, fifo_wrclk}, {63'b0, gmii_rx_clk});
    if (!rst_n) begin
      check("rst_wrreq", {63'b0, fif.fifo_wrreq}, 64'd0);
      check("rst_done", {63'b0, rx_done}, 64'd0);
      check("rst_len", {48'b0, rx_data_length}, 64'd0);
      check("rst_dst", {16'b0, rx_dst_mac}, 64'd0);
      exp_wr.delete();
      held_dst = '0; held_src = '0; held_typ = '0; held_len = '0;
    end else begin
      if (fif.fifo_wrreq) begin
        wr_cnt++;
        if (exp_wr.size() == 0) fail_event("unexpected_write");
        else check("fifo_data", {56'b0, fif.fifo_data}, {56'b0, exp_wr.pop_front()});
      end
      if (rx_done) begin
        done_cnt++;
        last_crc_ok = rx_crc_ok;
        last_err    = rx_err;
        if (exp_done.size() == 0) begin
          fail_event("unexpected_rx_done");
        end else begin
          cur = exp_done.pop_front();
          check("done_dst", {16'b0, rx_dst_mac}, {16'b0, cur.dst});
          check("done_src", {16'b0, rx_src_mac}, {16'b0, cur.src});
          check("done_type", {48'b0, rx_frame_type}, {48'b0, cur.typ});
          check("done_len", {48'b0, rx_data_length}, {48'b0, cur.len});
          check("done_crc_ok", {63'b0, rx_crc_ok}, {63'b0, cur.crc_ok});
          check("done_err", {63'b0, rx_err}, {63'b0, cur.err});
          check("writes_before_done", 64'(exp_wr.size()), 64'd0);
          held_dst = cur.dst; held_src = cur.src; held_typ = cur.typ; held_len = cur.len;
        end
      end else begin
        check("hold_dst", {16'b0, rx_dst_mac}, {16'b0, held_dst});
        check("hold_src", {16'b0, rx_src_mac}, {16'b0, held_src});
        check("hold_type", {48'b0, rx_frame_type}, {48'b0, held_typ});
        check("hold_len", {48'b0, rx_data_length}, {48'b0, held_len});
      end
    end
  end

  task automatic drive(input logic [7:0] b, input logic e);
    @(negedge gmii_rx_clk);
    gmii_rx_data = b;
    gmii_rx_dv   = 1'b1;
    gmii_rx_er   = e;
  endtask

  // Sends one frame built from pay[]; positions index the byte stream after SFD.
  task automatic send_frame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                            input int pre_len, input int flip_pos, input int er_pos,
                            input int cut, input int rst_pos, input int ifg);
    logic [7:0]  s[$];
    logic [31:0] c;
    int          n, nd, nw, nwc;
    bit          runt, ovs;
    done_t       d;
    s = {};
    for (int i = 0; i < 6; i++) s.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) s.push_back(src[47-8*i -: 8]);
    s.push_back(typ[15:8]);
    s.push_back(typ[7:0]);
    foreach (pay[i]) s.push_back(pay[i]);
    c = '1;
    foreach (s[i]) c = crc_upd(c, s[i]);
    c = ~c;
    s.push_back(c[7:0]); s.push_back(c[15:8]); s.push_back(c[23:16]); s.push_back(c[31:24]);
    if (flip_pos >= 0 && flip_pos < s.size()) s[flip_pos] = s[flip_pos] ^ 8'hFF;
    n = (cut >= 0 && cut < s.size()) ? cut : s.size();

    for (int i = 0; i < pre_len; i++) drive(8'h55, 1'b0);
    drive(8'hD5, 1'b0);

    if (n >= 14 && (dst == local_mac_addr || dst == BCAST)) begin
      nd  = n - 14;
      nw  = (nd > 4) ? nd - 4 : 0;
      nwc = (nw > MAXP) ? MAXP : nw;
      for (int i = 0; i < nwc; i++) exp_wr.push_back(s[14+i]);
      runt = (nd < 4);
      ovs  = (nw > MAXP);
      c = '1;
      for (int i = 0; i < n; i++) c = crc_upd(c, s[i]);
      d.dst = dst; d.src = src; d.typ = typ; d.len = 16'(nwc);
      d.crc_ok = !runt && (c == RESIDUE);
      d.err    = (er_pos >= 0 && er_pos < n) || runt || ovs;
      if (rst_pos < 0) exp_done.push_back(d);
    end

    for (int i = 0; i < n; i++) begin
      if (i == rst_pos) begin
        @(negedge gmii_rx_clk);
        rst_n = 1'b0; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rx_data = '0;
        repeat (3) @(negedge gmii_rx_clk);
        rst_n = 1'b1;
        repeat (2) @(negedge gmii_rx_clk);
        return;
      end
      drive(s[i], (i == er_pos));
    end
    @(negedge gmii_rx_clk);
    gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rx_data = '0;
    repeat (ifg - 1) @(negedge gmii_rx_clk);
  endtask

  task automatic fill_pay(input int len, input int mode);
    pay = {};
    for (int i = 0; i < len; i++) pay.push_back(mode == 0 ? 8'(i * 3 + 1) : 8'($urandom));
  endtask

  initial begin
    logic [31:0] c;
    string       str;
    int          w0, d0, plen, sel;
    logic [47:0] dst, loc;
    loc = 48'h0007_EDAC_6201;
    rst_n = 1'b1; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rx_data = '0;
    local_mac_addr = loc;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge gmii_rx_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge gmii_rx_clk);

    // Standard CRC-32 check value pins the model's CRC routine.
    str = "123456789";
    c = '1;
    for (int i = 0; i < 9; i++) c = crc_upd(c, str[i]);
    check("crc_check_value", {32'b0, ~c}, 64'hCBF43926);

    // Broadcast ARP, 46-byte payload.
    fill_pay(46, 0);
    w0 = wr_cnt; d0 = done_cnt;
    send_frame(BCAST, 48'h0007_EDAC_6200, 16'h0806, 7, -1, -1, -1, -1, 12);
    check("arp_writes", 64'(wr_cnt - w0), 64'd46);
    check("arp_done", 64'(done_cnt - d0), 64'd1);
    check("arp_len", {48'b0, rx_data_length}, 64'd46);
    check("arp_type", {48'b0, rx_frame_type}, 64'h0806);
    check("arp_src", {16'b0, rx_src_mac}, 64'h0007EDAC6200);
    check("arp_crc_ok", {63'b0, last_crc_ok}, 64'd1);
    check("arp_err", {63'b0, last_err}, 64'd0);

    // Foreign unicast is filtered; previous status holds.
    w0 = wr_cnt; d0 = done_cnt;
    send_frame(48'h1122_3344_5566, 48'h0007_EDAC_6200, 16'h0806, 7, -1, -1, -1, -1, 12);
    check("filt_writes", 64'(wr_cnt - w0), 64'd0);
    check("filt_done", 64'(done_cnt - d0), 64'd0);
    check("filt_hold_dst", {16'b0, rx_dst_mac}, 64'hFFFFFFFFFFFF);
    check("filt_hold_len", {48'b0, rx_data_length}, 64'd46);

    // Unicast to local with payload byte 10 corrupted.
    w0 = wr_cnt;
    send_frame(loc, 48'h0007_EDAC_6200, 16'h0800, 7, 14 + 10, -1, -1, -1, 12);
    check("flip_writes", 64'(wr_cnt - w0), 64'd46);
    check("flip_crc_ok", {63'b0, last_crc_ok}, 64'd0);
    check("flip_err", {63'b0, last_err}, 64'd0);

    // rx_er on payload byte 20.
    send_frame(loc, 48'h0007_EDAC_6200, 16'h0800, 7, -1, 14 + 20, -1, -1, 12);
    check("rxer_err", {63'b0, last_err}, 64'd1);

    // Runt: dv drops after 2 DATA bytes.
    send_frame(loc, 48'h0007_EDAC_6200, 16'h0800, 7, -1, -1, 14 + 2, -1, 12);
    check("runt_len", {48'b0, rx_data_length}, 64'd0);
    check("runt_err", {63'b0, last_err}, 64'd1);
    check("runt_crc_ok", {63'b0, last_crc_ok}, 64'd0);

    // Reset at payload byte 30, then a clean frame.
    d0 = done_cnt;
    send_frame(loc, 48'h0007_EDAC_6200, 16'h0800, 7, -1, -1, -1, 14 + 30, 12);
    check("rst_frame_done", 64'(done_cnt - d0), 64'd0);
    send_frame(BCAST, 48'hA0B0_C0D0_E0F0, 16'h0800, 1, -1, -1, -1, -1, 12);
    check("post_rst_crc_ok", {63'b0, last_crc_ok}, 64'd1);
    check("post_rst_done", 64'(done_cnt - d0), 64'd1);

    // Back-to-back with a 1-cycle gap.
    d0 = done_cnt;
    fill_pay(60, 1);
    send_frame(loc, 48'h0000_0000_0001, 16'h0800, 7, -1, -1, -1, -1, 1);
    fill_pay(47, 1);
    send_frame(loc, 48'h0000_0000_0002, 16'h86DD, 7, -1, -1, -1, -1, 12);
    check("b2b_done", 64'(done_cnt - d0), 64'd2);
    check("b2b_len2", {48'b0, rx_data_length}, 64'd47);

    // Oversize: 1501 payload bytes.
    w0 = wr_cnt;
    fill_pay(1501, 1);
    send_frame(loc, 48'h0000_0000_0003, 16'h0800, 7, -1, -1, -1, -1, 12);
    check("ovs_writes", 64'(wr_cnt - w0), 64'd1500);
    check("ovs_len", {48'b0, rx_data_length}, 64'd1500);
    check("ovs_err", {63'b0, last_err}, 64'd1);

    // Randomized frames.
    for (int k = 0; k < 30; k++) begin
      plen = $urandom_range(0, 80);
      fill_pay(plen, 1);
      sel = $urandom_range(0, 2);
      dst = (sel == 0) ? loc : (sel == 1) ? BCAST : {16'($urandom), 32'($urandom)};
      send_frame(dst, {16'($urandom), 32'($urandom)}, 16'($urandom), $urandom_range(2, 7),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, 14 + plen + 3) : -1,
                 ($urandom_range(0, 4) == 0) ? $urandom_range(0, 14 + plen + 3) : -1,
                 ($urandom_range(0, 4) == 0) ? $urandom_range(0, 14 + plen + 4) : -1,
                 -1, $urandom_range(1, 4));
    end

    repeat (20) @(negedge gmii_rx_clk);
    check("pending_writes", 64'(exp_wr.size()), 64'd0);
    check("pending_done", 64'(exp_done.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
